// File: rtl/tmr_error_monitor.sv
// tmr_error_monitor: consumer end of the voter error network for one clock
// domain. Turns raw tmrErr flags into counted, latched, software-visible
// status and schedules scrub pulses (periodic plus early after an error) that
// force the self-correcting TMR registers to reload. This block is plain,
// non-triplicated logic and is kept out of the triplication flow.
module tmr_error_monitor #(
  parameter int N_ERR        = 8,
  parameter int CNT_W        = 16,
  parameter int SCRUB_PERIOD = 1024,
  parameter int SCRUB_LEN    = 2,
  parameter int IRQ_THRESH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ERR-1:0]         err_in,
  input  logic                     scrub_en,
  input  logic                     clear,
  output logic                     scrub_req,
  output logic [CNT_W-1:0]         err_count,
  output logic [N_ERR-1:0]         err_flags,
  output logic [$clog2(N_ERR)-1:0] first_err_idx,
  output logic                     first_err_valid,
  output logic                     err_irq
);

  localparam int IDX_W = $clog2(N_ERR);
  localparam int PC_W  = $clog2(N_ERR + 1);
  localparam int PER_W = $clog2(SCRUB_PERIOD);
  localparam int LEN_W = $clog2(SCRUB_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_SCRUB = 2'd2;

  logic [N_ERR-1:0] r_err_q;
  logic [N_ERR-1:0] w_rise;
  logic [PC_W-1:0]  w_pop;
  logic [IDX_W-1:0] w_low_idx;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_rise_any;

  logic [CNT_W-1:0] r_err_count;
  logic [N_ERR-1:0] r_err_flags;
  logic [IDX_W-1:0] r_first_idx;
  logic             r_first_valid;
  logic             r_err_irq;

  logic [1:0]       r_state;
  logic [PER_W-1:0] r_per_cnt;
  logic [LEN_W-1:0] r_len_cnt;
  logic             r_scrub_req;

  // Register err_in so a level held high is seen as a single rising event.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_q    <= '0;
      r_rise_any <= 1'b0;
    end else begin
      r_err_q    <= err_in;
      r_rise_any <= |w_rise;
    end
  end

  assign w_rise = err_in & ~r_err_q;

  // Popcount of this cycle's rises and the lowest rising index.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_pop     = '0;
    w_low_idx = '0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      w_pop = w_pop + PC_W'(w_rise[i]);
      if (w_rise[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Saturating next count; clear zeroes the base so a same-cycle rise still lands.
  always_comb begin
    w_cnt_base = clear ? '0 : r_err_count;
    w_sum      = {1'b0, w_cnt_base} + (CNT_W + 1)'(w_pop);
    w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  // Error status: count, sticky flags, first-error capture and threshold irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count   <= '0;
      r_err_flags   <= '0;
      r_first_idx   <= '0;
      r_first_valid <= 1'b0;
      r_err_irq     <= 1'b0;
    end else begin
      r_err_count <= w_cnt_next;
      r_err_flags <= (clear ? '0 : r_err_flags) | w_rise;
      // irq follows the registered count, so it lags err_count by one cycle.
      r_err_irq   <= (r_err_count >= CNT_W'(IRQ_THRESH));
      if ((clear || !r_first_valid) && (w_rise != '0)) begin
        r_first_idx   <= w_low_idx;
        r_first_valid <= 1'b1;
      end else if (clear) begin
        r_first_idx   <= '0;
        r_first_valid <= 1'b0;
      end
    end
  end

  // Scrub scheduler: periodic pulses, plus an early pulse one cycle after a
  // registered rise. scrub_req is its own flop so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_len_cnt   <= '0;
      r_scrub_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_per_cnt <= '0;
          if (scrub_en) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (!scrub_en) begin
            r_state   <= S_IDLE;
            r_per_cnt <= '0;
          end else if (r_rise_any || (r_per_cnt == PER_W'(SCRUB_PERIOD - 1))) begin
            r_state     <= S_SCRUB;
            r_per_cnt   <= '0;
            r_len_cnt   <= '0;
            r_scrub_req <= 1'b1;
          end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
          end
        end
        S_SCRUB: begin
          // Pulse length is fixed; scrub_en and new rises are ignored until done.
          if (r_len_cnt == LEN_W'(SCRUB_LEN - 1)) begin
            r_scrub_req <= 1'b0;
            r_state     <= scrub_en ? S_COUNT : S_IDLE;
          end else begin
            r_len_cnt <= r_len_cnt + LEN_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_per_cnt   <= '0;
          r_len_cnt   <= '0;
          r_scrub_req <= 1'b0;
        end
      endcase
    end
  end

  assign scrub_req       = r_scrub_req;
  assign err_count       = r_err_count;
  assign err_flags       = r_err_flags;
  assign first_err_idx   = r_first_idx;
  assign first_err_valid = r_first_valid;
  assign err_irq         = r_err_irq;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Self-checking bench for tmr_error_monitor with default parameters.
// Status outputs are predicted by a behavioural model and compared through a
// one-deep scoreboard queue; scrub timing is measured against fixed numbers.
module tb_tmr_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  err_in;
  logic        scrub_en;
  logic        clear;
  logic        scrub_req;
  logic [15:0] err_count;
  logic [7:0]  err_flags;
  logic [2:0]  first_err_idx;
  logic        first_err_valid;
  logic        err_irq;

  tmr_error_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .err_in          (err_in),
    .scrub_en        (scrub_en),
    .clear           (clear),
    .scrub_req       (scrub_req),
    .err_count       (err_count),
    .err_flags       (err_flags),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid),
    .err_irq         (err_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic [7:0]  flags;
    logic [2:0]  idx;
    logic        valid;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] m_prev;
  int         m_cnt;
  logic [7:0] m_flags;
  logic [2:0] m_idx;
  logic       m_valid;
  logic       m_irq;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_cnt   = 0;
    m_flags = '0;
    m_idx   = '0;
    m_valid = 1'b0;
    m_irq   = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, predict status, then compare after the edge.
  task automatic step(input logic [7:0] e, input logic c);
    logic [7:0] rise;
    logic       irq_new;
    exp_t       x;
    err_in  = e;
    clear   = c;
    rise    = e & ~m_prev;
    m_prev  = e;
    irq_new = (m_cnt >= 4);
    if (c) begin
      m_cnt   = 0;
      m_flags = '0;
      m_idx   = '0;
      m_valid = 1'b0;
    end
    m_cnt = m_cnt + $countones(rise);
    if (m_cnt > 65535) m_cnt = 65535;
    m_flags = m_flags | rise;
    if (!m_valid && rise != 8'h00) begin
      for (int i = 7; i >= 0; i--) if (rise[i]) m_idx = 3'(i);
      m_valid = 1'b1;
    end
    m_irq = irq_new;
    x = '{cnt: 16'(m_cnt), flags: m_flags, idx: m_idx, valid: m_valid, irq: m_irq};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("err_count", {16'h0, err_count}, {16'h0, x.cnt});
    check("err_flags", {24'h0, err_flags}, {24'h0, x.flags});
    check("first_err_idx", {29'h0, first_err_idx}, {29'h0, x.idx});
    check("first_err_valid", {31'h0, first_err_valid}, {31'h0, x.valid});
    check("err_irq", {31'h0, err_irq}, {31'h0, x.irq});
  endtask

  initial begin
    int highs;
    int prev;
    int hi_len;
    int rises[$];
    int lens[$];

    rst      = 1'b1;
    err_in   = '0;
    scrub_en = 1'b0;
    clear    = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_scrub_req", {31'h0, scrub_req}, 32'h0);
    check("rst_err_count", {16'h0, err_count}, 32'h0);
    check("rst_err_flags", {24'h0, err_flags}, 32'h0);
    check("rst_valid", {31'h0, first_err_valid}, 32'h0);
    check("rst_irq", {31'h0, err_irq}, 32'h0);
    rst = 1'b0;

    // Idle: scrub disabled, no errors.
    highs = 0;
    for (int k = 0; k < 2000; k++) begin
      step(8'h00, 1'b0);
      if (scrub_req) highs++;
    end
    check("idle_no_scrub", highs, 0);

    // Periodic scrubbing over five periods.
    scrub_en = 1'b1;
    prev   = 0;
    hi_len = 0;
    for (int k = 1; k <= 1025 + 4 * 1026 + 3; k++) begin
      step(8'h00, 1'b0);
      if (scrub_req && prev == 0) rises.push_back(k);
      if (scrub_req) hi_len++;
      else if (prev != 0) begin
        lens.push_back(hi_len);
        hi_len = 0;
      end
      prev = int'(scrub_req);
    end
    check("period_pulses", rises.size(), 5);
    check("period_lens", lens.size(), 5);
    if (rises.size() > 0) check("first_scrub_edge", rises[0], 1025);
    for (int i = 1; i < rises.size(); i++) check("scrub_period", rises[i] - rises[i-1], 1026);
    for (int i = 0; i < lens.size(); i++) check("scrub_len", lens[i], 2);

    // Error-triggered scrub and event counting.
    scrub_en = 1'b0;
    for (int k = 0; k < 10; k++) step(8'h00, 1'b0);
    check("disabled_scrub", {31'h0, scrub_req}, 32'h0);
    scrub_en = 1'b1;
    for (int k = 0; k < 5; k++) step(8'h00, 1'b0);
    step(8'h24, 1'b0);
    check("early_scrub_t1", {31'h0, scrub_req}, 32'h0);
    step(8'h04, 1'b0);
    check("early_scrub_t2", {31'h0, scrub_req}, 32'h1);
    for (int k = 0; k < 49; k++) step(8'h04, 1'b0);
    check("held_count", {16'h0, err_count}, 32'd2);
    check("held_flags", {24'h0, err_flags}, 32'h24);
    check("held_idx", {29'h0, first_err_idx}, 32'd2);
    check("held_valid", {31'h0, first_err_valid}, 32'h1);

    // Threshold interrupt and clear.
    step(8'h00, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(8'h80, 1'b0);
      if (j == 3) begin
        check("irq_count4", {16'h0, err_count}, 32'd4);
        check("irq_lag", {31'h0, err_irq}, 32'h0);
      end
      step(8'h00, 1'b0);
      if (j == 3) check("irq_set", {31'h0, err_irq}, 32'h1);
    end
    step(8'h00, 1'b1);
    check("clr_count", {16'h0, err_count}, 32'h0);
    check("clr_flags", {24'h0, err_flags}, 32'h0);
    check("clr_valid", {31'h0, first_err_valid}, 32'h0);
    step(8'h00, 1'b0);
    check("clr_irq_drop", {31'h0, err_irq}, 32'h0);

    // Clear coincident with a rise: the new event wins.
    step(8'h02, 1'b0);
    step(8'h08, 1'b1);
    check("clr_rise_count", {16'h0, err_count}, 32'd1);
    check("clr_rise_flags", {24'h0, err_flags}, 32'h08);
    check("clr_rise_idx", {29'h0, first_err_idx}, 32'd3);
    check("clr_rise_valid", {31'h0, first_err_valid}, 32'h1);

    // Saturation.
    step(8'h00, 1'b1);
    for (int k = 0; k < 8191; k++) begin
      step(8'hFF, 1'b0);
      step(8'h00, 1'b0);
    end
    step(8'h3F, 1'b0);
    check("sat_fffe", {16'h0, err_count}, 32'hFFFE);
    step(8'h00, 1'b0);
    step(8'h07, 1'b0);
    check("sat_ffff", {16'h0, err_count}, 32'hFFFF);
    step(8'h00, 1'b0);
    step(8'h07, 1'b0);
    check("sat_hold", {16'h0, err_count}, 32'hFFFF);

    // Asynchronous reset in the middle of a scrub pulse.
    for (int k = 0; k < 10; k++) step(8'h00, 1'b0);
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    check("pre_rst_scrub", {31'h0, scrub_req}, 32'h1);
    err_in = 8'h10;
    rst    = 1'b1;
    #1;
    check("async_rst_scrub", {31'h0, scrub_req}, 32'h0);
    check("async_rst_count", {16'h0, err_count}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(8'h10, 1'b0);
    check("rise_after_rst", {16'h0, err_count}, 32'd1);
    check("rise_after_rst_idx", {29'h0, first_err_idx}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
